// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, event FSM
// states and the single-key decode helpers used on the debounced matrix.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    // Event FSM: waiting for a lone key, or tracking an accepted key.
    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_e;

    // Result of decoding a key mask: whether exactly one bit is set, and
    // the position of the lowest set bit.
    typedef struct packed {
        logic       valid_single;
        logic [3:0] index;
    } key_onehot_t;

    // Exactly-one-bit check with lowest-set-bit index.
    function automatic key_onehot_t onehot_index(input logic [NUM_KEYS-1:0] mask);
        key_onehot_t res;
        logic        seen;
        logic        multi;
        res   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (mask[i]) begin
                if (seen) begin
                    multi = 1'b1;
                end else begin
                    res.index = 4'(i);
                end
                seen = 1'b1;
            end
        end
        res.valid_single = seen & ~multi;
        return res;
    endfunction

    // Snapshot bits are laid out column-major (col*4+row) because a whole
    // column is captured at once; key codes are row-major (row*4+col).
    function automatic logic [3:0] snap_index_to_code(input logic [3:0] snap_idx);
        return {snap_idx[1:0], snap_idx[3:2]};
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debouncer: a full-matrix snapshot must repeat unchanged for
// DEBOUNCE_SCANS consecutive frames before it becomes the debounced state.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_done,
    input  logic [NUM_KEYS-1:0] snapshot,
    output logic [NUM_KEYS-1:0] debounced
);

    logic [NUM_KEYS-1:0] prev_snapshot_q, prev_snapshot_d;
    logic [NUM_KEYS-1:0] debounced_q, debounced_d;
    logic [3:0]          stable_cnt_q, stable_cnt_d;
    logic [4:0]          stable_inc;
    logic                frame_equal;

    // Compare each finished frame with its predecessor and track the run length.
    always_comb begin
        prev_snapshot_d = prev_snapshot_q;
        debounced_d     = debounced_q;
        stable_cnt_d    = stable_cnt_q;
        frame_equal     = (snapshot == prev_snapshot_q);
        // Five bits so the threshold test cannot wrap when the count is at 15.
        stable_inc      = {1'b0, stable_cnt_q} + 5'd1;
        if (frame_done) begin
            prev_snapshot_d = snapshot;
            if (frame_equal) begin
                stable_cnt_d = (stable_cnt_q == 4'hF) ? 4'hF : stable_inc[3:0];
                if (stable_inc >= 5'(DEBOUNCE_SCANS)) begin
                    debounced_d = snapshot;
                end
            end else begin
                stable_cnt_d = 4'h0;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_snapshot_q <= '0;
            debounced_q     <= '0;
            stable_cnt_q    <= 4'h0;
        end else begin
            prev_snapshot_q <= prev_snapshot_d;
            debounced_q     <= debounced_d;
            stable_cnt_q    <= stable_cnt_d;
        end
    end

    assign debounced = debounced_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: rotates the column drive, samples the
// synchronized rows once per column dwell, debounces whole frames and turns
// lone key presses into key_valid / key_release strobes with a hex key code.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 5000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] key_row,
    output logic [NUM_COLS-1:0] key_col,
    output logic [3:0]          key_code,
    output logic                key_valid,
    output logic                key_release,
    output logic                key_held
);

    localparam int                 DWELL_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [1:0]         COL_LAST   = 2'(NUM_COLS - 1);

    // Row synchronizer
    logic [NUM_ROWS-1:0] row_meta_q;
    logic [NUM_ROWS-1:0] row_sync_q;

    // Column scan and sampling
    logic [DWELL_W-1:0]  dwell_q, dwell_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [NUM_KEYS-1:0] snapshot_q, snapshot_d;
    logic                frame_done_q, frame_done_d;
    logic                sample_now;

    // Debounced matrix and event FSM
    logic [NUM_KEYS-1:0] debounced;
    key_onehot_t         deb_onehot;
    key_state_e          state_q, state_d;
    logic [3:0]          key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_release_q, key_release_d;
    logic                key_held_q, key_held_d;

    // Two-flop synchronizer; idle rows are pulled up, so reset to all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
        end else begin
            row_meta_q <= key_row;
            row_sync_q <= row_meta_q;
        end
    end

    // Dwell counter, column rotation and the frame-complete strobe.
    always_comb begin
        sample_now   = (dwell_q == DWELL_LAST);
        dwell_d      = sample_now ? '0 : dwell_q + DWELL_W'(1);
        col_idx_d    = sample_now ? col_idx_q + 2'd1 : col_idx_q;
        // Registered so the debouncer sees the snapshot with column 3 written.
        frame_done_d = sample_now && (col_idx_q == COL_LAST);
    end

    // Each column owns four snapshot bits, written only on its own sample
    // cycle; the rows are inverted so a closed key reads as 1.
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
        assign key_col[gi] = (col_idx_q != 2'(gi));
        assign snapshot_d[gi*NUM_ROWS +: NUM_ROWS] =
            (sample_now && (col_idx_q == 2'(gi))) ? ~row_sync_q
                                                  : snapshot_q[gi*NUM_ROWS +: NUM_ROWS];
    end

    // Scan state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dwell_q      <= '0;
            col_idx_q    <= 2'd0;
            snapshot_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            col_idx_q    <= col_idx_d;
            snapshot_q   <= snapshot_d;
            frame_done_q <= frame_done_d;
        end
    end

    keypad_frame_debounce #(
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_done (frame_done_q),
        .snapshot   (snapshot_q),
        .debounced  (debounced)
    );

    assign deb_onehot = onehot_index(debounced);

    // Event decisions: accept only a lone key from IDLE; leave HELD only
    // once the matrix is completely clear, so chords and rollover are ignored.
    always_comb begin
        state_d       = state_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_release_d = 1'b0;
        // Held stays up through the release cycle and drops on the next one.
        key_held_d    = (state_q == HELD);
        case (state_q)
            IDLE: begin
                if (deb_onehot.valid_single) begin
                    state_d     = HELD;
                    key_code_d  = snap_index_to_code(deb_onehot.index);
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
                end
            end
            HELD: begin
                if (debounced == '0) begin
                    state_d       = IDLE;
                    key_release_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered event outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
            key_held_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
            key_held_q    <= key_held_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;
    assign key_held    = key_held_q;

endmodule
